// File: rtl/sc_io_pkg.sv
// Shared I/O address map, key debounce state encoding and decode helper for sc_io_port.
package sc_io_pkg;

    localparam int IO_SEL_BIT = 7;

    localparam logic [7:0] ADDR_OUT0 = 8'h80;
    localparam logic [7:0] ADDR_OUT1 = 8'h84;
    localparam logic [7:0] ADDR_LED  = 8'h88;
    localparam logic [7:0] ADDR_SW   = 8'hC0;
    localparam logic [7:0] ADDR_KEY  = 8'hC4;
    localparam logic [7:0] ADDR_EVT  = 8'hC8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_PRESS,
        ST_PRESSED,
        ST_WAIT_RELEASE
    } deb_state_t;

    // Word-granular decode: the byte-offset bits never take part in the match.
    function automatic logic io_match(input logic [7:0] a, input logic [7:0] base);
        return a[7:2] == base[7:2];
    endfunction

endpackage

// File: rtl/sc_io_port_key.sv
// One push-button channel: two-flop synchroniser, optional debounce FSM (SC_IO_DEBOUNCE_EN), sticky event.
// Synchroniser resets to 1 so a released (active-low) key reads as idle straight out of reset.
module sc_key_debounce
    import sc_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_key_n,
    input  logic i_evt_clr,
    output logic o_level,
    output logic o_event
);

    logic [1:0] r_sync;
    logic       r_evt;
    logic       w_key_n;
    logic       w_evt_set;

    always_ff @(posedge clock) begin
        if (reset) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], i_key_n};
    end

    assign w_key_n = r_sync[1];

    // A set and a clear landing on the same edge leave the bit set.
    always_ff @(posedge clock) begin
        if (reset) r_evt <= 1'b0;
        else       r_evt <= w_evt_set | (r_evt & ~i_evt_clr);
    end

    assign o_event = r_evt;

`ifdef SC_IO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] C_MAX  = CW'(DEBOUNCE_CYCLES);

    deb_state_t      r_state;
    deb_state_t      w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic            w_done;

    always_comb begin
        w_state_nxt = r_state;
        w_evt_set   = 1'b0;
        w_done      = (r_cnt == C_LAST);
        case (r_state)
            ST_IDLE:         if (!w_key_n) w_state_nxt = ST_WAIT_PRESS;
            ST_WAIT_PRESS: begin
                if (w_key_n) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_done) begin
                    w_state_nxt = ST_PRESSED;
                    w_evt_set   = 1'b1;
                end
            end
            ST_PRESSED:      if (w_key_n) w_state_nxt = ST_WAIT_RELEASE;
            ST_WAIT_RELEASE: begin
                if (!w_key_n)    w_state_nxt = ST_PRESSED;
                else if (w_done) w_state_nxt = ST_IDLE;
            end
            default:         w_state_nxt = ST_IDLE;
        endcase
    end

    // Counter restarts on every state change, otherwise counts up and saturates.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) r_cnt <= '0;
            else if (r_cnt != C_MAX)    r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_level = (r_state == ST_PRESSED) || (r_state == ST_WAIT_RELEASE);
`else
    logic r_key_d;
    logic w_unused_cfg;

    always_ff @(posedge clock) begin
        if (reset) r_key_d <= 1'b1;
        else       r_key_d <= w_key_n;
    end

    assign w_evt_set    = r_key_d & ~w_key_n;
    assign o_level      = ~w_key_n;
    assign w_unused_cfg = (DEBOUNCE_CYCLES > 0);
`endif

endmodule

// File: rtl/sc_io_port.sv
// Memory-mapped I/O port: splits CPU loads/stores between data memory and LED/hex/switch/key registers.
// Key debounce FSMs are built only when SC_IO_DEBOUNCE_EN is defined; otherwise keys are edge-detected raw.
module sc_io_port
    import sc_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic        we,
    input  logic [31:0] mem_dataout,
    output logic        mem_we,
    output logic [31:0] dataout,
    input  logic [9:0]  sw,
    input  logic [2:0]  key,
    output logic [9:0]  led,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1
);

    logic [31:0] r_out0;
    logic [31:0] r_out1;
    logic [9:0]  r_led;
    logic [9:0]  r_sw_s1;
    logic [9:0]  r_sw_s2;
    logic        w_io;
    logic        w_io_wr;
    logic        w_evt_clr;
    logic [2:0]  w_key_level;
    logic [2:0]  w_key_event;
    logic [31:0] w_io_rdata;
    logic        w_unused_addr;

    assign w_io      = addr[IO_SEL_BIT];
    assign w_io_wr   = we & w_io;
    assign w_evt_clr = ~we & io_match(addr[7:0], ADDR_EVT);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= sw;
            r_sw_s2 <= r_sw_s1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_key
        sc_key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_key (
            .clock     (clock),
            .reset     (reset),
            .i_key_n   (key[i]),
            .i_evt_clr (w_evt_clr),
            .o_level   (w_key_level[i]),
            .o_event   (w_key_event[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out0 <= '0;
            r_out1 <= '0;
            r_led  <= '0;
        end else if (w_io_wr) begin
            if (io_match(addr[7:0], ADDR_OUT0))      r_out0 <= datain;
            else if (io_match(addr[7:0], ADDR_OUT1)) r_out1 <= datain;
            else if (io_match(addr[7:0], ADDR_LED))  r_led  <= datain[9:0];
        end
    end

    always_comb begin
        w_io_rdata = '0;
        if (io_match(addr[7:0], ADDR_SW))        w_io_rdata = {22'b0, r_sw_s2};
        else if (io_match(addr[7:0], ADDR_KEY))  w_io_rdata = {29'b0, w_key_level};
        else if (io_match(addr[7:0], ADDR_EVT))  w_io_rdata = {29'b0, w_key_event};
        else if (io_match(addr[7:0], ADDR_OUT0)) w_io_rdata = r_out0;
        else if (io_match(addr[7:0], ADDR_OUT1)) w_io_rdata = r_out1;
        else if (io_match(addr[7:0], ADDR_LED))  w_io_rdata = {22'b0, r_led};
    end

    assign dataout   = w_io ? w_io_rdata : mem_dataout;
    assign mem_we    = we & ~w_io;
    assign led       = r_led;
    assign out_port0 = r_out0;
    assign out_port1 = r_out1;

    assign w_unused_addr = ^{addr[31:8], addr[1:0]};

endmodule

// File: tb/tb_sc_io_port.sv
// Directed bench for sc_io_port with DEBOUNCE_CYCLES=4; key expectations follow SC_IO_DEBOUNCE_EN.
module tb_sc_io_port;

    logic        clock;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        we;
    logic [31:0] mem_dataout;
    logic        mem_we;
    logic [31:0] dataout;
    logic [9:0]  sw;
    logic [2:0]  key;
    logic [9:0]  led;
    logic [31:0] out_port0;
    logic [31:0] out_port1;

    int total = 0;
    int bad   = 0;

`ifdef SC_IO_DEBOUNCE_EN
    localparam int  SET_EDGE = 7;
    localparam bit  DEB      = 1'b1;
`else
    localparam int  SET_EDGE = 3;
    localparam bit  DEB      = 1'b0;
`endif

    sc_io_port #(.DEBOUNCE_CYCLES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .addr        (addr),
        .datain      (datain),
        .we          (we),
        .mem_dataout (mem_dataout),
        .mem_we      (mem_we),
        .dataout     (dataout),
        .sw          (sw),
        .key         (key),
        .led         (led),
        .out_port0   (out_port0),
        .out_port1   (out_port1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic load(input logic [31:0] a);
        addr = a;
        we   = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(2);
        load(32'h80);
        total++; if (out_port0 !== 32'h0) begin bad++; $display("FAIL rst_out0 got=%h exp=%h", out_port0, 32'h0); end
        total++; if (out_port1 !== 32'h0) begin bad++; $display("FAIL rst_out1 got=%h exp=%h", out_port1, 32'h0); end
        total++; if (led !== 10'h0) begin bad++; $display("FAIL rst_led got=%h exp=%h", led, 10'h0); end
        load(32'hC4);
        total++; if (dataout !== 32'h0) begin bad++; $display("FAIL rst_keylvl got=%h exp=%h", dataout, 32'h0); end
        load(32'hC8);
        total++; if (dataout !== 32'h0) begin bad++; $display("FAIL rst_keyevt got=%h exp=%h", dataout, 32'h0); end
        addr = 32'h10; we = 1'b1; mem_dataout = 32'hA5A5_0001; #1;
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rst_memwe got=%b exp=1", mem_we); end
        total++; if (dataout !== 32'hA5A5_0001) begin bad++; $display("FAIL rst_memrd got=%h exp=%h", dataout, 32'hA5A5_0001); end
        we = 1'b0;
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_io_store;
        addr = 32'h80; datain = 32'h1234_5678; we = 1'b1; #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL io_memwe got=%b exp=0", mem_we); end
        total++; if (out_port0 !== 32'h0) begin bad++; $display("FAIL io_pre_edge got=%h exp=%h", out_port0, 32'h0); end
        tick(1);
        we = 1'b0; #1;
        total++; if (out_port0 !== 32'h1234_5678) begin bad++; $display("FAIL io_out0 got=%h exp=%h", out_port0, 32'h1234_5678); end
        load(32'h80);
        total++; if (dataout !== 32'h1234_5678) begin bad++; $display("FAIL io_ld80 got=%h exp=%h", dataout, 32'h1234_5678); end
        addr = 32'h84; datain = 32'hCAFE_F00D; we = 1'b1; tick(1);
        addr = 32'h88; datain = 32'hFFFF_F3A5; tick(1);
        we = 1'b0;
        total++; if (out_port1 !== 32'hCAFE_F00D) begin bad++; $display("FAIL io_out1 got=%h exp=%h", out_port1, 32'hCAFE_F00D); end
        total++; if (led !== 10'h3A5) begin bad++; $display("FAIL io_led got=%h exp=%h", led, 10'h3A5); end
        load(32'h88);
        total++; if (dataout !== 32'h0000_03A5) begin bad++; $display("FAIL io_ld88 got=%h exp=%h", dataout, 32'h3A5); end
        load(32'h87);
        total++; if (dataout !== 32'hCAFE_F00D) begin bad++; $display("FAIL io_ld87 got=%h exp=%h", dataout, 32'hCAFE_F00D); end
    endtask

    task automatic test_mem_store;
        addr = 32'h10; datain = 32'hDEAD_BEEF; we = 1'b1; mem_dataout = 32'h0; #1;
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL mem_we got=%b exp=1", mem_we); end
        tick(1);
        we = 1'b0; mem_dataout = 32'hDEAD_BEEF; #1;
        total++; if (dataout !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mem_ld got=%h exp=%h", dataout, 32'hDEAD_BEEF); end
        total++; if (out_port0 !== 32'h1234_5678 || out_port1 !== 32'hCAFE_F00D || led !== 10'h3A5) begin
            bad++; $display("FAIL mem_regs got=%h/%h/%h exp=12345678/cafef00d/3a5", out_port0, out_port1, led);
        end
    endtask

    task automatic test_unmapped;
        addr = 32'hCC; datain = 32'h0BAD_0BAD; we = 1'b1; #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL unm_memwe got=%b exp=0", mem_we); end
        tick(1);
        load(32'hCC);
        total++; if (dataout !== 32'h0) begin bad++; $display("FAIL unm_ld got=%h exp=%h", dataout, 32'h0); end
        total++; if (out_port0 !== 32'h1234_5678 || out_port1 !== 32'hCAFE_F00D || led !== 10'h3A5) begin
            bad++; $display("FAIL unm_regs got=%h/%h/%h exp=12345678/cafef00d/3a5", out_port0, out_port1, led);
        end
    endtask

    task automatic test_sw_sync;
        sw = 10'h2A5;
        load(32'hC0);
        total++; if (dataout !== 32'h0) begin bad++; $display("FAIL sw_e0 got=%h exp=%h", dataout, 32'h0); end
        tick(1);
        total++; if (dataout !== 32'h0) begin bad++; $display("FAIL sw_e1 got=%h exp=%h", dataout, 32'h0); end
        tick(1);
        total++; if (dataout !== 32'h2A5) begin bad++; $display("FAIL sw_e2 got=%h exp=%h", dataout, 32'h2A5); end
        tick(1);
        total++; if (dataout !== 32'h2A5) begin bad++; $display("FAIL sw_e3 got=%h exp=%h", dataout, 32'h2A5); end
    endtask

    task automatic test_key_short;
        logic [31:0] exp_evt;
        exp_evt = DEB ? 32'h0 : 32'h2;
        addr = 32'h10;
        key = 3'b101; tick(3);
        key = 3'b111; tick(12);
        load(32'hC8);
        total++; if (dataout !== exp_evt) begin bad++; $display("FAIL key_short_evt got=%h exp=%h", dataout, exp_evt); end
        tick(1);
        total++; if (dataout !== 32'h0) begin bad++; $display("FAIL key_short_clr got=%h exp=%h", dataout, 32'h0); end
        addr = 32'h10;
    endtask

    task automatic test_key_press;
        addr = 32'h10;
        key = 3'b101; tick(6);
        key = 3'b111; tick(12);
        load(32'hC8);
        total++; if (dataout !== 32'h2) begin bad++; $display("FAIL key_press_evt got=%h exp=%h", dataout, 32'h2); end
        tick(1);
        total++; if (dataout !== 32'h0) begin bad++; $display("FAIL key_press_clr got=%h exp=%h", dataout, 32'h0); end
        addr = 32'h10;
    endtask

    task automatic test_key_level;
        addr = 32'h10;
        key = 3'b110; tick(10);
        load(32'hC4);
        total++; if (dataout !== 32'h1) begin bad++; $display("FAIL key_lvl_held got=%h exp=%h", dataout, 32'h1); end
        key = 3'b111; addr = 32'h10; tick(15);
        load(32'hC4);
        total++; if (dataout !== 32'h0) begin bad++; $display("FAIL key_lvl_rel got=%h exp=%h", dataout, 32'h0); end
        load(32'hC8); tick(1);
        total++; if (dataout !== 32'h0) begin bad++; $display("FAIL key_lvl_evtclr got=%h exp=%h", dataout, 32'h0); end
        addr = 32'h10;
    endtask

    task automatic test_set_wins;
        addr = 32'h10;
        key = 3'b101; tick(SET_EDGE - 1);
        load(32'hC8);
        total++; if (dataout !== 32'h0) begin bad++; $display("FAIL setwin_pre got=%h exp=%h", dataout, 32'h0); end
        tick(1);
        total++; if (dataout !== 32'h2) begin bad++; $display("FAIL setwin_same got=%h exp=%h", dataout, 32'h2); end
        tick(1);
        total++; if (dataout !== 32'h0) begin bad++; $display("FAIL setwin_clr got=%h exp=%h", dataout, 32'h0); end
        addr = 32'h10;
        key = 3'b111; tick(15);
    endtask

    task automatic test_reset_mid_debounce;
        logic [31:0] exp_lvl;
        exp_lvl = DEB ? 32'h0 : 32'h4;
        addr = 32'h10;
        key = 3'b011; tick(4);
        load(32'hC4);
        total++; if (dataout !== exp_lvl) begin bad++; $display("FAIL rmid_lvl got=%h exp=%h", dataout, exp_lvl); end
        reset = 1'b1; key = 3'b111; addr = 32'h10; tick(1);
        reset = 1'b0; tick(10);
        load(32'hC4);
        total++; if (dataout !== 32'h0) begin bad++; $display("FAIL rmid_lvl_after got=%h exp=%h", dataout, 32'h0); end
        load(32'hC8);
        total++; if (dataout !== 32'h0) begin bad++; $display("FAIL rmid_evt got=%h exp=%h", dataout, 32'h0); end
        total++; if (out_port0 !== 32'h0) begin bad++; $display("FAIL rmid_out0 got=%h exp=%h", out_port0, 32'h0); end
    endtask

    initial begin
        reset = 1'b1; addr = 32'h0; datain = 32'h0; we = 1'b0;
        mem_dataout = 32'h0; sw = 10'h0; key = 3'b111;
        test_reset;
        test_io_store;
        test_mem_store;
        test_unmapped;
        test_sw_sync;
        test_key_short;
        test_key_press;
        test_key_level;
        test_set_wins;
        test_reset_mid_debounce;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sc_io_port.md
SC_IO_PORT -- requirements
Module: sc_io_port

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: stable cycles required before a key level is accepted.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 addr  input  32  CPU data address.
REQ-005 datain  input  32  CPU store data.
REQ-006 we  input  1  CPU store enable.
REQ-007 mem_dataout  input  32  read data returned by data memory.
REQ-008 mem_we  output  1  store enable forwarded to data memory.
REQ-009 dataout  output  32  load data returned to CPU.
REQ-010 sw  input  10  slide switches, asynchronous.
REQ-011 key  input  3  push-buttons, asynchronous, active-low.
REQ-012 led  output  10  LED drive.
REQ-013 out_port0, out_port1  output  32 each  hex-display data words.

Function
REQ-014 addr[7]=1 selects I/O space; addr[7]=0 selects memory; decode uses addr[7:2] only.
REQ-015 mem_we = we & ~addr[7]; an I/O store never reaches memory.
REQ-016 Store map (registered on rising edge when we & addr[7]): 0x80 -> out_port0, 0x84 -> out_port1, 0x88 -> led (datain[9:0]); new value visible one cycle after the store edge.
REQ-017 Stores to any other I/O address are ignored.
REQ-018 Load map, combinational: 0xC0 -> {22'b0, sw_sync}; 0xC4 -> {29'b0, key_level}; 0xC8 -> {29'b0, key_event}; 0x80/0x84/0x88 -> current register contents (led zero-extended); other I/O addresses -> 0.
REQ-019 dataout = mem_dataout when addr[7]=0, else I/O load value.
REQ-020 sw passes through a two-flop synchroniser; an sw change appears at 0xC0 two edges later.
REQ-021 Each key bit passes through a two-flop synchroniser and a debounce FSM: IDLE (released) -> WAIT_PRESS on sync low; WAIT_PRESS -> PRESSED after DEBOUNCE_CYCLES consecutive lows, else back to IDLE on any high; PRESSED -> WAIT_RELEASE on sync high; WAIT_RELEASE -> IDLE after DEBOUNCE_CYCLES consecutive highs, else back to PRESSED on any low.
REQ-022 key_level[i] = 1 in PRESSED and WAIT_RELEASE; counter restarts from 0 on every state entry and saturates at DEBOUNCE_CYCLES.
REQ-023 key_event[i] sets on the WAIT_PRESS -> PRESSED transition and is sticky.
REQ-024 A load of 0xC8 (addr match, we=0) clears key_event at that rising edge; when a set and a clear of the same bit occur in the same cycle, set wins.
REQ-025 Loads from 0xC0/0xC4 have no side effects.

Reset
REQ-026 On reset: out_port0, out_port1, led = 0; synchronisers = 0 for sw and 1 for key; all debounce FSMs = IDLE with counters = 0; key_event = 0.
REQ-027 Reset asserted mid-debounce abandons the count; no event is raised for a press in progress.
REQ-028 mem_we and dataout remain combinational and are valid during reset.

Configuration
REQ-029 Macro SC_IO_DEBOUNCE_EN defined: the debounce FSMs of REQ-021..023 are present.
REQ-030 Macro SC_IO_DEBOUNCE_EN absent: key_level = ~synchronised key; key_event sets on a synchronised falling key edge; FSMs, counters and DEBOUNCE_CYCLES have no effect.

Structure
REQ-031 Package sc_io_pkg holds the I/O address constants (0x80, 0x84, 0x88, 0xC0, 0xC4, 0xC8), the debounce state enum and the I/O-select bit index.
REQ-032 Sub-module sc_key_debounce (synchroniser, FSM, counter, event pulse) is instantiated once per key bit.

Verification
REQ-033 Store 0x12345678 to 0x80 -> out_port0 = 0x12345678 next cycle; mem_we = 0 during the store; a load of 0x80 returns 0x12345678.
REQ-034 Store 0xDEADBEEF to 0x10 -> mem_we = 1; the I/O registers are unchanged; a load of 0x10 with mem_dataout = 0xDEADBEEF returns 0xDEADBEEF.
REQ-035 Set sw = 10'h2A5 -> a load of 0xC0 returns 0x2A5 from the second edge onward; before then it returns the old value.
REQ-036 DEBOUNCE_CYCLES=4, key[1] low for 3 cycles then high -> no event. Key[1] low for 6 cycles -> a load of 0xC8 returns 0x2; the next load of 0xC8 returns 0.
REQ-037 Event set and a 0xC8 load in the same cycle -> the bit remains 1. Reset asserted during WAIT_PRESS -> key_level = 0 and key_event = 0.
REQ-038 Store to 0xCC, then load 0xCC -> returns 0; out_port0, out_port1 and led are unchanged.
